// File: rtl/sram_dp_arb.sv
// rtl/sram_dp_arb.sv - dual-port SRAM arbiter with power-on clear and collision priority
// Clears the SRAM after reset, then arbitrates two requesters onto the two memory ports.
module sram_dp_arb #(
   parameter int depth = 256,
   parameter int width = 16,
   localparam int AW = $clog2(depth)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_A,
   input  logic             req_B,
   input  logic             wr_A,
   input  logic             wr_B,
   input  logic [AW-1:0]    add_A,
   input  logic [AW-1:0]    add_B,
   input  logic [width-1:0] data_inA,
   input  logic [width-1:0] data_inB,
   output logic             gnt_A,
   output logic             gnt_B,
   output logic             rvalid_A,
   output logic             rvalid_B,
   output logic [width-1:0] data_outA,
   output logic [width-1:0] data_outB,
   output logic             mem_cs,
   output logic             mem_we_A,
   output logic             mem_re_A,
   output logic             mem_we_B,
   output logic             mem_re_B,
   output logic [AW-1:0]    mem_add_A,
   output logic [AW-1:0]    mem_add_B,
   output logic [width-1:0] mem_din_A,
   output logic [width-1:0] mem_din_B,
   input  logic [width-1:0] mem_dout_A,
   input  logic [width-1:0] mem_dout_B,
   output logic             init_done,
   output logic [7:0]       coll_cnt
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    init_addr_q, init_addr_d;
   logic             init_done_q, init_done_d;
   logic             prio_b_q, prio_b_d;
   logic [7:0]       coll_cnt_q, coll_cnt_d;
   logic             mem_cs_q, mem_cs_d;
   logic             mem_we_a_q, mem_we_a_d;
   logic             mem_re_a_q, mem_re_a_d;
   logic             mem_we_b_q, mem_we_b_d;
   logic             mem_re_b_q, mem_re_b_d;
   logic [AW-1:0]    mem_add_a_q, mem_add_a_d;
   logic [AW-1:0]    mem_add_b_q, mem_add_b_d;
   logic [width-1:0] mem_din_a_q, mem_din_a_d;
   logic [width-1:0] mem_din_b_q, mem_din_b_d;
   logic             rd_pipe_a_q, rd_pipe_a_d;
   logic             rd_pipe_b_q, rd_pipe_b_d;
   logic             rvalid_a_q, rvalid_a_d;
   logic             rvalid_b_q, rvalid_b_d;
   logic [width-1:0] data_out_a_q, data_out_a_d;
   logic [width-1:0] data_out_b_q, data_out_b_d;

   logic run;
   logic coll;
   logic gnt_a;
   logic gnt_b;

   // Same-address reads never conflict; any write to a shared address does.
   assign run   = (state_q == ST_RUN);
   assign coll  = req_A & req_B & (add_A == add_B) & (wr_A | wr_B);
   assign gnt_a = run & req_A & (~coll | ~prio_b_q);
   assign gnt_b = run & req_B & (~coll | prio_b_q);

   always_comb begin
      state_d      = state_q;
      init_addr_d  = init_addr_q;
      init_done_d  = init_done_q;
      prio_b_d     = prio_b_q;
      coll_cnt_d   = coll_cnt_q;
      mem_cs_d     = 1'b0;
      mem_we_a_d   = 1'b0;
      mem_re_a_d   = 1'b0;
      mem_we_b_d   = 1'b0;
      mem_re_b_d   = 1'b0;
      mem_add_a_d  = mem_add_a_q;
      mem_add_b_d  = mem_add_b_q;
      mem_din_a_d  = mem_din_a_q;
      mem_din_b_d  = mem_din_b_q;
      // Read data is registered in the SRAM, so it lands two edges after issue.
      rd_pipe_a_d  = mem_re_a_q;
      rd_pipe_b_d  = mem_re_b_q;
      rvalid_a_d   = rd_pipe_a_q;
      rvalid_b_d   = rd_pipe_b_q;
      data_out_a_d = rd_pipe_a_q ? mem_dout_A : data_out_a_q;
      data_out_b_d = rd_pipe_b_q ? mem_dout_B : data_out_b_q;

      case (state_q)
         ST_INIT: begin
            mem_cs_d    = 1'b1;
            mem_we_a_d  = 1'b1;
            mem_we_b_d  = 1'b1;
            mem_add_a_d = init_addr_q;
            mem_add_b_d = init_addr_q | AW'(1);
            mem_din_a_d = '0;
            mem_din_b_d = '0;
            if (init_addr_q == AW'(depth - 2)) begin
               state_d = ST_RUN;
            end else begin
               init_addr_d = init_addr_q + AW'(2);
            end
         end
         ST_RUN: begin
            init_done_d = 1'b1;
            if (gnt_a) begin
               mem_cs_d    = 1'b1;
               mem_we_a_d  = wr_A;
               mem_re_a_d  = ~wr_A;
               mem_add_a_d = add_A;
               mem_din_a_d = data_inA;
            end
            if (gnt_b) begin
               mem_cs_d    = 1'b1;
               mem_we_b_d  = wr_B;
               mem_re_b_d  = ~wr_B;
               mem_add_b_d = add_B;
               mem_din_b_d = data_inB;
            end
            // Priority passes to the loser so a persistent collision alternates.
            if (coll) begin
               prio_b_d = ~prio_b_q;
               if (coll_cnt_q != 8'hFF) begin
                  coll_cnt_d = coll_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         init_addr_q  <= '0;
         init_done_q  <= 1'b0;
         prio_b_q     <= 1'b0;
         coll_cnt_q   <= '0;
         mem_cs_q     <= 1'b0;
         mem_we_a_q   <= 1'b0;
         mem_re_a_q   <= 1'b0;
         mem_we_b_q   <= 1'b0;
         mem_re_b_q   <= 1'b0;
         mem_add_a_q  <= '0;
         mem_add_b_q  <= '0;
         mem_din_a_q  <= '0;
         mem_din_b_q  <= '0;
         rd_pipe_a_q  <= 1'b0;
         rd_pipe_b_q  <= 1'b0;
         rvalid_a_q   <= 1'b0;
         rvalid_b_q   <= 1'b0;
         data_out_a_q <= '0;
         data_out_b_q <= '0;
      end else begin
         state_q      <= state_d;
         init_addr_q  <= init_addr_d;
         init_done_q  <= init_done_d;
         prio_b_q     <= prio_b_d;
         coll_cnt_q   <= coll_cnt_d;
         mem_cs_q     <= mem_cs_d;
         mem_we_a_q   <= mem_we_a_d;
         mem_re_a_q   <= mem_re_a_d;
         mem_we_b_q   <= mem_we_b_d;
         mem_re_b_q   <= mem_re_b_d;
         mem_add_a_q  <= mem_add_a_d;
         mem_add_b_q  <= mem_add_b_d;
         mem_din_a_q  <= mem_din_a_d;
         mem_din_b_q  <= mem_din_b_d;
         rd_pipe_a_q  <= rd_pipe_a_d;
         rd_pipe_b_q  <= rd_pipe_b_d;
         rvalid_a_q   <= rvalid_a_d;
         rvalid_b_q   <= rvalid_b_d;
         data_out_a_q <= data_out_a_d;
         data_out_b_q <= data_out_b_d;
      end
   end

   assign gnt_A     = gnt_a;
   assign gnt_B     = gnt_b;
   assign rvalid_A  = rvalid_a_q;
   assign rvalid_B  = rvalid_b_q;
   assign data_outA = data_out_a_q;
   assign data_outB = data_out_b_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we_A  = mem_we_a_q;
   assign mem_re_A  = mem_re_a_q;
   assign mem_we_B  = mem_we_b_q;
   assign mem_re_B  = mem_re_b_q;
   assign mem_add_A = mem_add_a_q;
   assign mem_add_B = mem_add_b_q;
   assign mem_din_A = mem_din_a_q;
   assign mem_din_B = mem_din_b_q;
   assign init_done = init_done_q;
   assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_sram_dp_arb.sv
// tb/tb_sram_dp_arb.sv - table-driven bench for sram_dp_arb with a registered-read SRAM model
module tb_sram_dp_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_A, req_B, wr_A, wr_B;
   logic [7:0]  add_A, add_B;
   logic [15:0] data_inA, data_inB;
   logic        gnt_A, gnt_B, rvalid_A, rvalid_B;
   logic [15:0] data_outA, data_outB;
   logic        mem_cs, mem_we_A, mem_re_A, mem_we_B, mem_re_B;
   logic [7:0]  mem_add_A, mem_add_B;
   logic [15:0] mem_din_A, mem_din_B;
   logic [15:0] mem_dout_A, mem_dout_B;
   logic        init_done;
   logic [7:0]  coll_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_dp_arb #(.depth(256), .width(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_A(req_A), .req_B(req_B), .wr_A(wr_A), .wr_B(wr_B),
      .add_A(add_A), .add_B(add_B), .data_inA(data_inA), .data_inB(data_inB),
      .gnt_A(gnt_A), .gnt_B(gnt_B), .rvalid_A(rvalid_A), .rvalid_B(rvalid_B),
      .data_outA(data_outA), .data_outB(data_outB),
      .mem_cs(mem_cs), .mem_we_A(mem_we_A), .mem_re_A(mem_re_A),
      .mem_we_B(mem_we_B), .mem_re_B(mem_re_B),
      .mem_add_A(mem_add_A), .mem_add_B(mem_add_B),
      .mem_din_A(mem_din_A), .mem_din_B(mem_din_B),
      .mem_dout_A(mem_dout_A), .mem_dout_B(mem_dout_B),
      .init_done(init_done), .coll_cnt(coll_cnt)
   );

   // Registered-read SRAM; preloaded with junk so the clear is observable.
   logic [15:0] mem [256] = '{default: 16'hDEAD};
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we_A) mem[mem_add_A] <= mem_din_A;
         if (mem_we_B) mem[mem_add_B] <= mem_din_B;
         if (mem_re_A) mem_dout_A <= mem[mem_add_A];
         if (mem_re_B) mem_dout_B <= mem[mem_add_B];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ra, wa;
      logic [7:0]  aa;
      logic [15:0] da;
      logic        rb, wb;
      logic [7:0]  ab;
      logic [15:0] db;
      logic        ga, gb;
      logic        rva;
      logic [15:0] doa;
      logic        rvb;
      logic [15:0] dob;
      logic [7:0]  cc;
   } vec_t;

   vec_t vec [13];

   initial begin
      int n;
      int bad;
      logic exp_prio_b;

      vec[0]  = '{0,0,8'd0, 16'h0000, 0,0,8'd0, 16'h0000, 0,0, 0,16'h0000, 0,16'h0000, 8'd0};
      vec[1]  = '{1,1,8'd5, 16'hAAAA, 1,1,8'd10,16'hBBBB, 1,1, 0,16'h0000, 0,16'h0000, 8'd0};
      vec[2]  = '{1,0,8'd5, 16'h0000, 1,0,8'd10,16'h0000, 1,1, 0,16'h0000, 0,16'h0000, 8'd0};
      vec[3]  = '{1,1,8'd15,16'h1234, 1,1,8'd15,16'h5678, 1,0, 0,16'h0000, 0,16'h0000, 8'd1};
      vec[4]  = '{0,0,8'd0, 16'h0000, 1,1,8'd15,16'h5678, 0,1, 1,16'hAAAA, 1,16'hBBBB, 8'd1};
      vec[5]  = '{1,0,8'd10,16'h0000, 1,0,8'd10,16'h0000, 1,1, 0,16'hAAAA, 0,16'hBBBB, 8'd1};
      vec[6]  = '{1,0,8'd15,16'h0000, 0,0,8'd0, 16'h0000, 1,0, 0,16'hAAAA, 0,16'hBBBB, 8'd1};
      vec[7]  = '{1,0,8'd20,16'h0000, 1,1,8'd21,16'h4321, 1,1, 1,16'hBBBB, 1,16'hBBBB, 8'd1};
      vec[8]  = '{1,1,8'd7, 16'h1111, 1,0,8'd7, 16'h0000, 0,1, 1,16'h5678, 0,16'hBBBB, 8'd2};
      vec[9]  = '{1,1,8'd7, 16'h1111, 0,0,8'd0, 16'h0000, 1,0, 1,16'h0000, 0,16'hBBBB, 8'd2};
      vec[10] = '{1,0,8'd7, 16'h0000, 0,0,8'd0, 16'h0000, 1,0, 0,16'h0000, 1,16'h0000, 8'd2};
      vec[11] = '{0,0,8'd0, 16'h0000, 0,0,8'd0, 16'h0000, 0,0, 0,16'h0000, 0,16'h0000, 8'd2};
      vec[12] = '{0,0,8'd0, 16'h0000, 0,0,8'd0, 16'h0000, 0,0, 1,16'h1111, 0,16'h0000, 8'd2};

      rst_n = 1'b0;
      req_A = 0; req_B = 0; wr_A = 0; wr_B = 0;
      add_A = 0; add_B = 0; data_inA = 0; data_inB = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {gnt_A, gnt_B, rvalid_A, rvalid_B, mem_cs, mem_we_A, mem_re_A,
                            mem_we_B, mem_re_B, init_done, (|data_outA), (|data_outB),
                            (|mem_add_A), (|mem_add_B), (|mem_din_A), (|mem_din_B), (|coll_cnt)}, 0);

      // A read to address 3 is held throughout INIT and must wait for RUN.
      req_A = 1; wr_A = 0; add_A = 8'd3;
      rst_n = 1'b1;
      n = 0;
      bad = 0;
      if (gnt_A) bad++;
      while (!init_done && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            chk("init_first_pair", {mem_cs, mem_we_A, mem_we_B, mem_re_A, mem_re_B, mem_add_A, mem_add_B},
                {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1});
         end
         if (n < 128 && gnt_A) bad++;
      end
      chk("init_done_latency", n, 129);
      chk("init_gnt_blocked", bad, 0);
      req_A = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("init_held_read", {rvalid_A, data_outA}, {1'b1, 16'h0000});
      @(posedge clk); #1;
      chk("rvalid_one_cycle", rvalid_A, 0);

      for (int i = 0; i < 13; i++) begin
         req_A = vec[i].ra; wr_A = vec[i].wa; add_A = vec[i].aa; data_inA = vec[i].da;
         req_B = vec[i].rb; wr_B = vec[i].wb; add_B = vec[i].ab; data_inB = vec[i].db;
         #1;
         chk($sformatf("v%0d_gnt", i), {gnt_A, gnt_B}, {vec[i].ga, vec[i].gb});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_mem_ctl", i), {mem_cs, mem_we_A, mem_re_A, mem_we_B, mem_re_B},
             {vec[i].ga | vec[i].gb, vec[i].ga & vec[i].wa, vec[i].ga & ~vec[i].wa,
              vec[i].gb & vec[i].wb, vec[i].gb & ~vec[i].wb});
         if (vec[i].ga) chk($sformatf("v%0d_mem_a", i), {mem_add_A, mem_din_A}, {vec[i].aa, vec[i].da});
         if (vec[i].gb) chk($sformatf("v%0d_mem_b", i), {mem_add_B, mem_din_B}, {vec[i].ab, vec[i].db});
         chk($sformatf("v%0d_rd_a", i), {rvalid_A, data_outA}, {vec[i].rva, vec[i].doa});
         chk($sformatf("v%0d_rd_b", i), {rvalid_B, data_outB}, {vec[i].rvb, vec[i].dob});
         chk($sformatf("v%0d_coll_cnt", i), coll_cnt, vec[i].cc);
      end

      // Persistent collision: grants must alternate from the current priority holder.
      exp_prio_b = 1'b0;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         req_A = 1; wr_A = 0; add_A = 8'd5; data_inA = 16'h0000;
         req_B = 1; wr_B = 1; add_B = 8'd5; data_inB = 16'h9999;
         #1;
         if (gnt_A !== ~exp_prio_b || gnt_B !== exp_prio_b) bad++;
         @(posedge clk);
         #1;
         exp_prio_b = ~exp_prio_b;
      end
      chk("coll_alternate", bad, 0);
      chk("coll_saturate", coll_cnt, 8'd255);
      req_A = 0; req_B = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset one cycle after a read is accepted discards it and restarts the clear.
      req_A = 1; wr_A = 0; add_A = 8'd10;
      #1;
      chk("pre_reset_gnt", gnt_A, 1);
      @(posedge clk);
      #1;
      req_A = 0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_mid_state", {init_done, rvalid_A, coll_cnt}, 0);
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (rvalid_A) bad++;
         if (k == 0) chk("init_restart", {mem_we_A, mem_add_A, init_done}, {1'b1, 8'd0, 1'b0});
      end
      chk("reset_drops_rvalid", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
